// File: rtl/sc_psum_line_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : sc_psum_line_buffer                                          |
// | Description : Multi-channel line buffer for stochastic-computing partial   |
// |               sums. Keeps KERNEL_HEIGHT-1 rows of per-column bitstreams,   |
// |               written with a KERNEL_WIDTH-1 column lag and read back one   |
// |               kernel row down, with registered read and write-first bypass.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sc_psum_line_buffer #(
  parameter int                KERNEL_HEIGHT = 3,
  parameter int                KERNEL_WIDTH  = 3,
  parameter int                INPUT_WIDTH   = 32,
  parameter int                SC_LEN        = 256,
  parameter int                NUM_CH        = 2,
  parameter logic [NUM_CH-1:0] ROW0_INIT     = 2'b10,
  // Column index carries every lagged store column (up to INPUT_WIDTH+KERNEL_WIDTH-2)
  // and still leaves room for an out-of-range value to be seen and flagged.
  localparam int               W_LOG         = $clog2(INPUT_WIDTH + KERNEL_WIDTH),
  localparam int               SC_LOG        = $clog2(SC_LEN)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            enable,
  input  logic                            fetch_req,
  input  logic [NUM_CH*KERNEL_HEIGHT-1:0] store_vals,
  input  logic [W_LOG-1:0]                width_index,
  input  logic [SC_LOG-1:0]               sc_count,
  output logic [NUM_CH*KERNEL_HEIGHT-1:0] fetch_vals,
  output logic                            fetch_valid,
  output logic                            row_done,
  output logic                            idx_err
);

  localparam int              c_KH        = KERNEL_HEIGHT;
  localparam int              c_ROWS      = KERNEL_HEIGHT - 1;
  localparam int              c_CW        = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam logic [W_LOG:0]  c_LAG       = (W_LOG+1)'(KERNEL_WIDTH - 1);
  localparam logic [W_LOG:0]  c_WIDTH     = (W_LOG+1)'(INPUT_WIDTH);
  localparam logic [W_LOG:0]  c_LAST_COL  = (W_LOG+1)'(INPUT_WIDTH - 1);
  localparam logic [SC_LOG:0] c_SC_LEN    = (SC_LOG+1)'(SC_LEN);
  localparam logic [SC_LOG-1:0] c_LAST_BIT = SC_LOG'(SC_LEN - 1);

  logic [W_LOG:0]             w_widx_ext;
  logic [W_LOG:0]             w_col;
  logic [SC_LOG:0]            w_sc_ext;
  logic                       w_lagged;
  logic                       w_sc_bad;
  logic                       w_store_bad;
  logic                       w_store_we;
  logic                       w_fetch_bad;
  logic                       w_fetch_ok;
  logic                       w_bypass;
  logic                       w_row_last;
  logic [c_CW-1:0]            w_col_idx;
  logic [c_CW-1:0]            w_fetch_idx;
  logic [NUM_CH*c_ROWS-1:0]   w_mem_rd;
  logic [NUM_CH*c_ROWS-1:0]   w_st_bit;
  logic [NUM_CH-1:0]          w_unused_top;
  logic [NUM_CH*c_KH-1:0]     w_fetch_next;

  // Column arithmetic is one bit wider than the index so a lagged column never wraps.
  assign w_widx_ext = {1'b0, width_index};
  assign w_sc_ext   = {1'b0, sc_count};
  assign w_col      = w_widx_ext - c_LAG;
  assign w_sc_bad   = (w_sc_ext >= c_SC_LEN);

  // Columns left of the lag window are simply not stored.
  if (KERNEL_WIDTH > 1) begin : g_lag
    assign w_lagged = (w_widx_ext >= c_LAG);
  end else begin : g_nolag
    assign w_lagged = 1'b1;
  end

  assign w_store_bad = enable & w_lagged & ((w_col >= c_WIDTH) | w_sc_bad);
  assign w_store_we  = enable & w_lagged & ~w_store_bad;
  assign w_fetch_bad = fetch_req & ((w_widx_ext >= c_WIDTH) | w_sc_bad);
  assign w_fetch_ok  = fetch_req & ~w_fetch_bad;

  // Same column and bit on the same edge: return the word being written.
  assign w_bypass    = w_store_we & (w_col == w_widx_ext);
  assign w_row_last  = w_store_we & (w_col == c_LAST_COL) & (sc_count == c_LAST_BIT);

  // Both indices are range-checked above, so the low bits address the storage.
  assign w_col_idx   = w_col[c_CW-1:0];
  assign w_fetch_idx = width_index[c_CW-1:0];

  for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
    // The bottom kernel row's partial sum has no later row to feed.
    assign w_unused_top[gc] = store_vals[gc*c_KH + c_KH - 1];

    for (genvar gi = 0; gi < c_ROWS; gi++) begin : g_row
      logic [SC_LEN-1:0] r_line [INPUT_WIDTH];

      // One stored kernel row: a bitstream word per column, one bit written per store.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int w = 0; w < INPUT_WIDTH; w++) begin
            r_line[w] <= '0;
          end
        end else if (clear) begin
          for (int w = 0; w < INPUT_WIDTH; w++) begin
            r_line[w] <= '0;
          end
        end else if (w_store_we) begin
          r_line[w_col_idx][sc_count] <= store_vals[gc*c_KH + gi];
        end
      end

      assign w_mem_rd[gc*c_ROWS + gi] = r_line[w_fetch_idx][sc_count];
      assign w_st_bit[gc*c_ROWS + gi] = store_vals[gc*c_KH + gi];
    end
  end

  // Next fetch word: constant row 0, stored rows shifted one kernel row down.
  always_comb begin
    w_fetch_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_fetch_next[c*c_KH] = ROW0_INIT[c];
      if (w_fetch_ok) begin
        for (int i = 1; i < c_KH; i++) begin
          w_fetch_next[c*c_KH + i] = w_bypass ? w_st_bit[c*c_ROWS + i - 1]
                                              : w_mem_rd[c*c_ROWS + i - 1];
        end
      end
    end
  end

  // Registered read data, valid strobe, row-done pulse and sticky index error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_vals  <= '0;
      fetch_valid <= 1'b0;
      row_done    <= 1'b0;
      idx_err     <= 1'b0;
    end else if (clear) begin
      fetch_vals  <= '0;
      fetch_valid <= 1'b0;
      row_done    <= 1'b0;
      idx_err     <= 1'b0;
    end else begin
      fetch_valid <= fetch_req;
      row_done    <= w_row_last;
      if (fetch_req) begin
        fetch_vals <= w_fetch_next;
      end
      if (w_store_bad | w_fetch_bad) begin
        idx_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
